// File: rtl/rr_mux32_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready output channel among 32 requesters.
// A grant is locked for a whole burst and released on a last beat or at the MAX_BURST cap.
module rr_mux32_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [31:0]           req_valid_i,
    input  logic [DATA_WIDTH-1:0] req_data_i [31:0],
    input  logic [31:0]           req_last_i,
    output logic [31:0]           req_ready_o,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_last_o,
    output logic [4:0]            out_src_o,
    input  logic                  out_ready_i,
    output logic                  busy_o
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE,
        LOCK
    } state_t;

    state_t                r_state;
    logic [4:0]            r_ptr;
    logic [4:0]            r_grant;
    logic [CNT_W-1:0]      r_beat_cnt;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_last;
    logic [4:0]            r_out_src;

    logic [4:0]            w_winner;
    logic                  w_out_free;
    logic                  w_xfer;
    logic                  w_end;
    logic [31:0]           w_ready;

    // Scanning downward lets the requester closest to r_ptr overwrite all others.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_winner = r_ptr;
        for (int k = 31; k >= 0; k--) begin
            if (req_valid_i[r_ptr + 5'(k)]) begin
                w_winner = r_ptr + 5'(k);
            end
        end
    end

    assign w_out_free = !r_out_valid || out_ready_i;
    assign w_xfer     = (r_state == LOCK) && w_out_free && req_valid_i[r_grant];
    assign w_end      = req_last_i[r_grant] || (r_beat_cnt == LAST_CNT);

    // Ready is offered to the locked requester whether or not it is currently valid.
    always_comb begin
        w_ready = '0;
        if (r_state == LOCK) begin
            w_ready[r_grant] = w_out_free;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: reset is synchronous, so it is tested inside the clocked block and only takes effect on an edge.
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_grant     <= '0;
            r_beat_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_src   <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
            case (r_state)
                IDLE: begin
                    if (|req_valid_i) begin
                        r_grant    <= w_winner;
                        r_beat_cnt <= '0;
                        r_state    <= LOCK;
                    end
                end
                LOCK: begin
                    if (w_xfer) begin
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                        if (w_end) begin
                            r_ptr   <= r_grant + 5'd1;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase

            // A new beat and a pop in the same cycle simply reload the register.
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= req_data_i[r_grant];
                r_out_last  <= w_end;
                r_out_src   <= r_grant;
            end else if (out_ready_i) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign req_ready_o = w_ready;
    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_data;
    assign out_last_o  = r_out_last;
    assign out_src_o   = r_out_src;
    assign busy_o      = (r_state == LOCK);

endmodule

// File: tb/tb_rr_mux32_arbiter.sv
// Self-checking bench for rr_mux32_arbiter: vector table, directed corner sequences,
// and randomized traffic compared every cycle against a transaction-level reference model.
module tb_rr_mux32_arbiter;

    localparam int DW = 32;
    localparam int MB = 16;

    typedef struct packed {
        logic [4:0]    src;
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct {
        logic        rst_n;
        logic [31:0] valid;
        logic [31:0] last;
        logic [23:0] d;
        logic        ordy;
        logic        e_ov;
        logic [31:0] e_od;
        logic        e_ol;
        logic [4:0]  e_os;
        logic        e_busy;
        logic [31:0] e_rdy;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   req_valid;
    logic [DW-1:0] req_data [31:0];
    logic [31:0]   req_last;
    logic [31:0]   req_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [4:0]    out_src;
    logic          out_ready;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    // Reference model state: plain integers, modulo-32 arithmetic.
    bit            m_lock;
    int            m_ptr, m_grant, m_cnt, m_os;
    logic          m_ov, m_ol;
    logic [DW-1:0] m_od;
    beat_t         acc[$];

    always #5 clk = ~clk;

    rr_mux32_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_valid_i(req_valid),
        .req_data_i (req_data),
        .req_last_i (req_last),
        .req_ready_o(req_ready),
        .out_valid_o(out_valid),
        .out_data_o (out_data),
        .out_last_o (out_last),
        .out_src_o  (out_src),
        .out_ready_i(out_ready),
        .busy_o     (busy)
    );

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] pack(input logic ov, input logic [31:0] od, input logic ol,
                                         input logic [4:0] os, input logic bz, input logic [31:0] rdy);
        return {ov, ol, bz, os, od, rdy};
    endfunction

    function automatic logic [71:0] dut_pack();
        return pack(out_valid, out_data, out_last, out_src, busy, req_ready);
    endfunction

    function automatic logic [31:0] model_ready();
        logic [31:0] r;
        r = '0;
        if (m_lock) r[m_grant] = !m_ov || out_ready;
        return r;
    endfunction

    // Advances the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit was_lock, fire, fin;
        int idx;
        if (!rst_n) begin
            m_lock = 0; m_ptr = 0; m_grant = 0; m_cnt = 0;
            m_ov = 0; m_ol = 0; m_od = '0; m_os = 0;
            return;
        end
        was_lock = m_lock;
        fire = was_lock && (!m_ov || out_ready) && req_valid[m_grant];
        if (fire) begin
            fin   = req_last[m_grant] || (m_cnt + 1 == MB);
            m_od  = req_data[m_grant];
            m_os  = m_grant;
            m_ol  = fin;
            m_ov  = 1;
            m_cnt = m_cnt + 1;
            if (fin) begin
                m_ptr  = (m_grant + 1) % 32;
                m_lock = 0;
            end
        end else if (out_ready) begin
            m_ov = 0;
        end
        if (!was_lock && req_valid != 0) begin
            for (int k = 0; k < 32; k++) begin
                idx = (m_ptr + k) % 32;
                if (req_valid[idx]) begin
                    m_grant = idx;
                    break;
                end
            end
            m_lock = 1;
            m_cnt  = 0;
        end
    endtask

    task automatic tick(input string name);
        if (rst_n && out_valid && out_ready) acc.push_back('{out_src, out_last, out_data});
        model_step();
        @(posedge clk);
        #1;
        check(name, dut_pack(), pack(m_ov, m_od, m_ol, 5'(m_os), m_lock, model_ready()));
    endtask

    task automatic set_data(input logic [23:0] base);
        for (int i = 0; i < 32; i++) req_data[i] = {8'(i), base};
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = '0; req_last = '0; out_ready = 1'b1;
        tick("reset");
        rst_n = 1'b1;
    endtask

    vec_t vecs[10];

    initial begin
        int sent;
        bit xfer;

        rst_n = 1'b0; req_valid = '0; req_last = '0; out_ready = 1'b1;
        set_data(24'h0);

        // Requester 5: three beats, then pointer checks via winners 7 (ptr=6) and 4 (ptr=8).
        vecs[0] = '{1'b0, 32'h0,        32'h0,        24'h0,  1'b1, 1'b0, 32'h0,        1'b0, 5'd0, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 32'h20,       32'h0,        24'hA0, 1'b1, 1'b0, 32'h0,        1'b0, 5'd0, 1'b1, 32'h20};
        vecs[2] = '{1'b1, 32'h20,       32'h0,        24'hA0, 1'b1, 1'b1, 32'h050000A0, 1'b0, 5'd5, 1'b1, 32'h20};
        vecs[3] = '{1'b1, 32'h20,       32'h0,        24'hA1, 1'b1, 1'b1, 32'h050000A1, 1'b0, 5'd5, 1'b1, 32'h20};
        vecs[4] = '{1'b1, 32'h20,       32'h20,       24'hA2, 1'b1, 1'b1, 32'h050000A2, 1'b1, 5'd5, 1'b0, 32'h0};
        vecs[5] = '{1'b1, 32'h0,        32'h0,        24'h0,  1'b1, 1'b0, 32'h050000A2, 1'b1, 5'd5, 1'b0, 32'h0};
        vecs[6] = '{1'b1, 32'h90,       32'h90,       24'hB0, 1'b1, 1'b0, 32'h050000A2, 1'b1, 5'd5, 1'b1, 32'h80};
        vecs[7] = '{1'b1, 32'h90,       32'h90,       24'hB0, 1'b1, 1'b1, 32'h070000B0, 1'b1, 5'd7, 1'b0, 32'h0};
        vecs[8] = '{1'b1, 32'h90,       32'h90,       24'hB1, 1'b1, 1'b0, 32'h070000B0, 1'b1, 5'd7, 1'b1, 32'h10};
        vecs[9] = '{1'b1, 32'h90,       32'h90,       24'hB1, 1'b1, 1'b1, 32'h040000B1, 1'b1, 5'd4, 1'b0, 32'h0};

        for (int v = 0; v < 10; v++) begin
            rst_n = vecs[v].rst_n; req_valid = vecs[v].valid; req_last = vecs[v].last;
            out_ready = vecs[v].ordy;
            set_data(vecs[v].d);
            model_step();
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", v), dut_pack(),
                  pack(vecs[v].e_ov, vecs[v].e_od, vecs[v].e_ol, vecs[v].e_os, vecs[v].e_busy, vecs[v].e_rdy));
        end

        // All 32 requesters valid with single-beat bursts: grant order 0..31 then 0.
        set_data(24'h11);
        do_reset();
        check("reset_zero", dut_pack(), 72'h0);
        acc.delete();
        req_valid = '1; req_last = '1; out_ready = 1'b1;
        for (int c = 0; c < 70; c++) tick("rr32");
        check("rr32_count", 72'(acc.size() >= 33), 72'(1));
        for (int i = 0; i < 33 && i < acc.size(); i++)
            check($sformatf("rr32_src%0d", i), 72'(acc[i].src), 72'(i % 32));

        // Wrap-around: 31 served, then 0 and 30 compete -> 0 first, then 30.
        do_reset();
        acc.delete();
        req_valid = 32'h8000_0000; req_last = '1;
        tick("wrap"); tick("wrap");
        req_valid = 32'h4000_0001;
        for (int c = 0; c < 5; c++) tick("wrap");
        check("wrap_count", 72'(acc.size()), 72'(3));
        if (acc.size() >= 3) begin
            check("wrap_first",  72'(acc[0].src), 72'(31));
            check("wrap_second", 72'(acc[1].src), 72'(0));
            check("wrap_third",  72'(acc[2].src), 72'(30));
        end

        // Requester 3 streams without last: forced release at beat 16, then 10 before 3 again.
        do_reset();
        acc.delete();
        req_valid = (32'h1 << 3) | (32'h1 << 10); req_last = 32'h1 << 10;
        for (int c = 0; c < 25; c++) tick("cap");
        check("cap_count", 72'(acc.size() >= 18), 72'(1));
        for (int i = 0; i < 16 && i < acc.size(); i++)
            check($sformatf("cap_beat%0d", i), 72'({acc[i].src, acc[i].last}), 72'({5'd3, i == 15}));
        if (acc.size() >= 18) begin
            check("cap_next",  72'(acc[16].src), 72'(10));
            check("cap_again", 72'(acc[17].src), 72'(3));
        end

        // Backpressure mid-burst: 8 numbered beats from requester 20, ready low for 4 cycles.
        do_reset();
        acc.delete();
        sent = 0;
        for (int cyc = 0; cyc < 60 && acc.size() < 8; cyc++) begin
            req_valid   = (sent < 8) ? (32'h1 << 20) : 32'h0;
            req_last    = (sent == 7) ? (32'h1 << 20) : 32'h0;
            req_data[20] = {8'd20, 24'(sent)};
            out_ready   = !(cyc >= 6 && cyc < 10);
            #1;
            xfer = req_valid[20] && req_ready[20];
            tick("bp");
            if (xfer) sent++;
        end
        check("bp_count", 72'(acc.size()), 72'(8));
        for (int i = 0; i < 8 && i < acc.size(); i++)
            check($sformatf("bp_beat%0d", i), 72'(acc[i]), 72'(beat_t'{5'd20, i == 7, {8'd20, 24'(i)}}));

        // Reset during LOCK with a held output beat, then check the pointer restarted at 0.
        do_reset();
        set_data(24'h55);
        req_valid = 32'h1 << 9; req_last = 32'h1 << 9;
        tick("rst_seq"); tick("rst_seq");
        req_valid = 32'h1 << 12; req_last = '0; out_ready = 1'b0;
        for (int c = 0; c < 4; c++) tick("rst_seq");
        rst_n = 1'b0;
        tick("rst_seq");
        check("rst_mid_lock", dut_pack(), 72'h0);
        rst_n = 1'b1; out_ready = 1'b1;
        req_valid = (32'h1 << 3) | (32'h1 << 11); req_last = '1;
        tick("rst_seq"); tick("rst_seq");
        check("rst_ptr_zero", 72'({out_valid, out_src}), 72'({1'b1, 5'd3}));

        // Randomized traffic, including occasional resets, compared cycle by cycle.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            rst_n = ($urandom_range(255) != 0);
            if ($urandom_range(1) == 0) req_valid = $urandom() & $urandom();
            if ($urandom_range(7) == 0) req_valid = '0;
            req_last = $urandom() & $urandom() & $urandom();
            for (int i = 0; i < 32; i++) req_data[i] = $urandom();
            out_ready = ($urandom_range(3) != 0);
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
